// File: rtl/mems_pkg.sv
// Shared constants, FSM state encoding and sample helpers for the MEMS
// delay-and-sum beamformer datapath.
package mems_pkg;

  localparam int CHANNELS = 4;                   // microphones, power of 2
  localparam int SAMPLE_W = 16;                  // signed sample width
  localparam int IDX_W    = 8;                   // log2 of delay-line depth
  localparam int CH_W     = 2;                   // log2(CHANNELS)
  localparam int SUM_W    = SAMPLE_W + CH_W;     // holds CHANNELS full-scale samples
  localparam int ADDR_W   = IDX_W + CH_W;        // RAM address {idx, ch}
  localparam int DEPTH    = 2 ** ADDR_W;         // RAM words

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [IDX_W-1:0]    idx_t;
  typedef logic [CH_W-1:0]     chan_t;

  // Sequencer FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  // Sign-extend one sample to accumulator width
  function automatic logic signed [SUM_W-1:0] sext_sample(input sample_t s);
    return $signed({{CH_W{s[SAMPLE_W-1]}}, s});
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Single-port sample RAM holding every microphone's circular delay line.
// Address is {idx, ch}; reads are registered (one-cycle latency).
// No reset on the array so it maps onto block RAM, whose configured
// contents are all-zero.
module sample_ram
  import mems_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem_r [DEPTH];

  // Write-first is irrelevant here: the sequencer never reads and writes in one cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/delay_sum_sequencer.sv
// Delay-and-sum sequencer: per accepted frame writes every mic sample into
// its delay line, reads each mic back at its programmed tap, and emits the
// signed sum. Owns the only port of the sample RAM (one access per cycle).
module delay_sum_sequencer
  import mems_pkg::*;
(
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         frame_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0] mic_data,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_chan,
  input  logic [IDX_W-1:0]             cfg_delay,
  output logic signed [SUM_W-1:0]      sum_out,
  output logic                         sum_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam chan_t LAST_CH = CH_W'(CHANNELS - 1);

  logic [2:0]                   state_r;
  chan_t                        ch_r;
  idx_t                         wr_idx_r;
  logic [CHANNELS*SAMPLE_W-1:0] mic_r;
  idx_t                         delay_r  [CHANNELS];
  idx_t                         shadow_r [CHANNELS];
  logic signed [SUM_W-1:0]      acc_r;
  logic                         rd_vld_r;

  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  sample_t           ram_wdata_s;
  sample_t           ram_rdata_s;
  idx_t              rd_idx_s;
  sample_t           mic_sel_s;

  sample_ram u_ram (
    .clk   (CLK),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // RAM port arbitration: writes during WRITE, tap reads during READ, idle otherwise
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = '0;
    ram_wdata_s = '0;
    mic_sel_s   = mic_r[ch_r*SAMPLE_W +: SAMPLE_W];
    rd_idx_s    = wr_idx_r - shadow_r[ch_r];   // IDX_W-bit wrap gives the circular tap
    case (state_r)
      ST_WRITE: begin
        ram_we_s    = 1'b1;
        ram_addr_s  = {wr_idx_r, ch_r};
        ram_wdata_s = mic_sel_s;
      end
      ST_READ: begin
        ram_we_s   = 1'b0;
        ram_addr_s = {rd_idx_s, ch_r};
      end
      default: begin
        ram_we_s    = 1'b0;
        ram_addr_s  = '0;
        ram_wdata_s = '0;
      end
    endcase
  end

  // Programmable delay taps; writable at any time, sampled into the shadow on accept
  always_ff @(posedge CLK) begin
    if (RST) begin
      delay_r <= '{default: '0};
    end else if (cfg_we) begin
      delay_r[cfg_chan] <= cfg_delay;
    end
  end

  // Sequencer FSM, accumulator and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      ch_r      <= '0;
      wr_idx_r  <= '0;
      mic_r     <= '0;
      shadow_r  <= '{default: '0};
      acc_r     <= '0;
      rd_vld_r  <= 1'b0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      // A read issued this cycle returns its word next cycle
      rd_vld_r  <= (state_r == ST_READ);
      if (rd_vld_r) begin
        acc_r <= acc_r + sext_sample(ram_rdata_s);
      end
      // Any frame offered outside IDLE (OUT included) is lost
      if (frame_valid && (state_r != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (frame_valid) begin
            mic_r    <= mic_data;
            shadow_r <= delay_r;
            ch_r     <= '0;
            busy     <= 1'b1;
            state_r  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          ch_r <= ch_r + CH_W'(1);
          if (ch_r == LAST_CH) begin
            acc_r   <= '0;          // no read is in flight while writing
            state_r <= ST_READ;
          end
        end
        ST_READ: begin
          ch_r <= ch_r + CH_W'(1);
          if (ch_r == LAST_CH) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_r <= ST_OUT;        // last read word is accumulated this cycle
        end
        ST_OUT: begin
          sum_out   <= acc_r;
          sum_valid <= 1'b1;
          wr_idx_r  <= wr_idx_r + IDX_W'(1);
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_sum_sequencer.sv
// Directed bench for delay_sum_sequencer with a frame-level reference model
// (per-channel history arrays, tap arithmetic mod 256) checked every cycle.
module tb_delay_sum_sequencer;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_valid;
  logic [63:0]       mic_data;
  logic              cfg_we;
  logic [1:0]        cfg_chan;
  logic [7:0]        cfg_delay;
  logic signed [17:0] sum_out;
  logic              sum_valid;
  logic              busy;
  logic              overrun;

  int total = 0;
  int bad   = 0;

  // reference model state
  int hist [4][256];
  int m_dly [4];
  int m_idx = 0;
  bit m_active = 1'b0;
  int m_acc_cyc = -100;
  int m_pend = 0;
  int m_sum = 0;
  bit m_ovr = 1'b0;
  bit exp_sv = 1'b0;
  bit exp_busy = 1'b0;
  int cyc = 0;
  int sv_cnt = 0;
  int last_sum = 0;

  always #5 clk = ~clk;

  delay_sum_sequencer dut (
    .CLK         (clk),
    .RST         (rst),
    .frame_valid (frame_valid),
    .mic_data    (mic_data),
    .cfg_we      (cfg_we),
    .cfg_chan    (cfg_chan),
    .cfg_delay   (cfg_delay),
    .sum_out     (sum_out),
    .sum_valid   (sum_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, expv);
    end
  endtask

  function automatic logic [63:0] pk(input int s3, input int s2, input int s1, input int s0);
    return {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
  endfunction

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_ovr    = 1'b0;
      m_sum    = 0;
      m_idx    = 0;
      for (int k = 0; k < 4; k++) m_dly[k] = 0;
    end else begin
      if (frame_valid) begin
        if (m_active && (cyc > m_acc_cyc) && (cyc <= m_acc_cyc + 10)) begin
          m_ovr = 1'b1;
        end else begin
          for (int k = 0; k < 4; k++)
            hist[k][m_idx] = int'($signed(mic_data[16*k +: 16]));
          m_pend = 0;
          for (int k = 0; k < 4; k++)
            m_pend += hist[k][(m_idx - m_dly[k]) & 255];
          m_idx     = (m_idx + 1) % 256;
          m_active  = 1'b1;
          m_acc_cyc = cyc;
        end
      end
      if (cfg_we) m_dly[cfg_chan] = int'(cfg_delay);
      if (m_active && (cyc == m_acc_cyc + 10)) m_sum = m_pend;
    end
    exp_sv   = !rst && m_active && (cyc == m_acc_cyc + 10);
    exp_busy = !rst && m_active && (cyc < m_acc_cyc + 10);
    @(negedge clk);
    check("sum_valid", sum_valid, exp_sv);
    check("busy", busy, exp_busy);
    check("overrun", overrun, m_ovr);
    check("sum_out", sum_out, m_sum);
    if (sum_valid === 1'b1) begin
      sv_cnt++;
      last_sum = int'(sum_out);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [63:0] d);
    mic_data    = d;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic cfg(input int ch, input int d);
    cfg_we    = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_delay = 8'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  // Full frame: pulse, wait the fixed latency, pin the result to a literal.
  task automatic run_frame(input string name, input logic [63:0] d,
                           input bit lit, input int expv);
    int n0;
    n0 = sv_cnt;
    pulse(d);
    repeat (10) tick();
    check({name, "_count"}, sv_cnt - n0, 1);
    if (lit) check(name, last_sum, expv);
  endtask

  initial begin
    int n0;
    rst = 1'b1; frame_valid = 1'b0; mic_data = 64'd0;
    cfg_we = 1'b0; cfg_chan = 2'd0; cfg_delay = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_sum_out", sum_out, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // basic sum and latency
    n0 = sv_cnt;
    pulse(pk(400, 300, 200, 100));
    check("busy_after_accept", busy, 1);
    repeat (9) tick();
    check("no_early_valid", sv_cnt - n0, 0);
    tick();
    check("valid_at_t10", sum_valid, 1);
    check("sum_1000", last_sum, 1000);
    check("busy_done", busy, 0);

    // delay of one frame on ch0
    do_reset();
    cfg(0, 1);
    run_frame("d1_first", pk(0, 0, 0, 10), 1'b1, 0);
    run_frame("d1_second", pk(0, 0, 0, 20), 1'b1, 10);

    // full-scale extremes
    cfg(0, 0);
    run_frame("neg_full", pk(-32768, -32768, -32768, -32768), 1'b1, -131072);
    check("neg_full_bits", {14'd0, sum_out}, 32'h0002_0000);
    run_frame("pos_full", pk(32767, 32767, 32767, 32767), 1'b1, 131068);

    // tap of 3 on ch1 across the wr_idx wrap
    do_reset();
    cfg(1, 3);
    for (int n = 0; n < 260; n++)
      run_frame("wrap", pk(0, 0, n, 0), (n >= 3), n - 3);

    // overrun: second frame while busy is dropped
    do_reset();
    n0 = sv_cnt;
    pulse(pk(0, 0, 0, 5));
    tick(); tick();
    pulse(pk(0, 0, 0, 99));
    repeat (7) tick();
    check("ovr_one_valid", sv_cnt - n0, 1);
    check("ovr_sum", last_sum, 5);
    check("ovr_sticky", overrun, 1);
    tick();
    run_frame("after_ovr", pk(0, 0, 0, 6), 1'b1, 6);
    check("ovr_still", overrun, 1);

    // delay written while busy applies from the next frame
    do_reset();
    n0 = sv_cnt;
    pulse(pk(0, 7, 0, 0));
    repeat (3) tick();
    cfg(2, 5);
    repeat (6) tick();
    check("cfg_busy_count", sv_cnt - n0, 1);
    check("cfg_old_delay", last_sum, 7);
    run_frame("cfg_new_delay", pk(0, 9, 0, 0), 1'b1, 0);

    // reset mid-sequence aborts the frame and clears the taps
    n0 = sv_cnt;
    pulse(pk(0, 1, 0, 0));
    repeat (4) tick();
    do_reset();
    repeat (10) tick();
    check("abort_no_valid", sv_cnt - n0, 0);
    check("abort_busy", busy, 0);
    check("abort_overrun", overrun, 0);
    run_frame("after_abort", pk(0, 11, 0, 0), 1'b1, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
